// File: rtl/mem_stage_ws_if.sv
// mem_stage_ws_if -- bus between the execute stage and the memory stage.
//   Upstream (master) drives: valid_in, PC_in, ALU_result, val_Rm,
//                             mem_read, mem_write
//   Stage (slave) drives:     stall, valid_out, PC_out, mem_result,
//                             wb_result, addr_err
// Parameter DATA_W must match the DATA_W of the attached mem_stage_ws.
interface mem_stage_ws_if #(
    parameter int DATA_W = 32
);
    logic              valid_in;
    logic [DATA_W-1:0] PC_in;
    logic [DATA_W-1:0] ALU_result;
    logic [DATA_W-1:0] val_Rm;
    logic              mem_read;
    logic              mem_write;
    logic              stall;
    logic              valid_out;
    logic [DATA_W-1:0] PC_out;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] wb_result;
    logic              addr_err;

    modport master (
        output valid_in, PC_in, ALU_result, val_Rm, mem_read, mem_write,
        input  stall, valid_out, PC_out, mem_result, wb_result, addr_err
    );

    modport slave (
        input  valid_in, PC_in, ALU_result, val_Rm, mem_read, mem_write,
        output stall, valid_out, PC_out, mem_result, wb_result, addr_err
    );
endinterface

// File: rtl/mem_stage_ws.sv
// mem_stage_ws -- pipeline memory stage with a data memory that needs
// WAIT_CYCLES wait states per access.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : mem_stage_ws_if.slave (instruction in, registered results out,
//          combinational stall back to upstream)
// Parameters: DATA_W, DEPTH (words), WAIT_CYCLES (0..15), BASE_ADDR (byte
// address of word 0).
// Optional macro MEM_STAGE_BOUNDS_CHECK_EN: when defined, accesses outside
// [BASE_ADDR, BASE_ADDR+4*DEPTH) suppress stores, return 0 on loads and raise
// addr_err; when undefined the word index simply wraps and addr_err is 0.
module mem_stage_ws #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic          clk,
    input  logic          rst,
    mem_stage_ws_if.slave bus
);
    localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;

    logic        mem_op, is_load;
    logic        pass, done, stall_c;
    logic        in_range;
    logic [AW-1:0] idx;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              valid_q;
    logic [DATA_W-1:0] pc_q, memres_q, wb_q;

    assign mem_op  = bus.mem_read | bus.mem_write;
    // Both requests high is a store, so a load needs mem_write low.
    assign is_load = bus.mem_read & ~bus.mem_write;
    assign idx     = AW'((bus.ALU_result - DATA_W'(BASE_ADDR)) >> 2);

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    // One extra bit so the upper bound cannot overflow the compare.
    localparam logic [DATA_W:0] LO = (DATA_W+1)'(BASE_ADDR);
    localparam logic [DATA_W:0] HI = (DATA_W+1)'(BASE_ADDR + 4 * DEPTH);
    logic err_q;

    assign in_range = ({1'b0, bus.ALU_result} >= LO) &&
                      ({1'b0, bus.ALU_result} <  HI);
    assign bus.addr_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= done & ~in_range;
    end
`else
    assign in_range     = 1'b1;
    assign bus.addr_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (bus.valid_in && mem_op && (WC != 4'd0)) begin
                    state_nx = WAIT;
                    cnt_nx   = WC - 4'd1;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nx = IDLE;
                else             cnt_nx   = cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: stall to upstream and the two ways an instruction retires
    // (pass = no memory op, done = memory access completes this edge).
    // Everything is masked by rst so a reset mid-access never writes memory.
    always_comb begin
        stall_c = 1'b0;
        pass    = 1'b0;
        done    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        if (!mem_op)            pass    = 1'b1;
                        else if (WC == 4'd0)    done    = 1'b1;
                        else                    stall_c = 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) stall_c = 1'b1;
                    else             done    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            memres_q <= '0;
            wb_q     <= '0;
        end else begin
            valid_q <= pass | done;
            if (pass) begin
                pc_q <= bus.PC_in;
                wb_q <= bus.ALU_result;
            end
            if (done) begin
                pc_q <= bus.PC_in;
                if (is_load) begin
                    if (in_range) begin
                        memres_q <= mem[idx];
                        wb_q     <= mem[idx];
                    end else begin
                        memres_q <= '0;
                        wb_q     <= '0;
                    end
                end else begin
                    wb_q <= bus.ALU_result;
                end
            end
        end
    end

    // Data memory: no reset, written only on the completion edge of a store.
    always_ff @(posedge clk) begin
        if (done && bus.mem_write && in_range) mem[idx] <= bus.val_Rm;
    end

    assign bus.stall      = stall_c;
    assign bus.valid_out  = valid_q;
    assign bus.PC_out     = pc_q;
    assign bus.mem_result = memres_q;
    assign bus.wb_result  = wb_q;
endmodule

// File: tb/tb_mem_stage_ws.sv
// tb_mem_stage_ws -- directed self-checking bench for mem_stage_ws.
// Two instances: d=2 uses WAIT_CYCLES=2, d=0 uses WAIT_CYCLES=0.
// Expected out-of-range behaviour follows MEM_STAGE_BOUNDS_CHECK_EN.
module tb_mem_stage_ws;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_stage_ws_if #(.DATA_W(32)) bus2 ();
    mem_stage_ws_if #(.DATA_W(32)) bus0 ();

    mem_stage_ws #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(2), .BASE_ADDR(1024))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mem_stage_ws #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0), .BASE_ADDR(1024))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic rd, input logic wr,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rm);
        if (d == 0) begin
            bus0.valid_in = v; bus0.mem_read = rd; bus0.mem_write = wr;
            bus0.PC_in = pc; bus0.ALU_result = alu; bus0.val_Rm = rm;
        end else begin
            bus2.valid_in = v; bus2.mem_read = rd; bus2.mem_write = wr;
            bus2.PC_in = pc; bus2.ALU_result = alu; bus2.val_Rm = rm;
        end
    endtask

    task automatic sample(input int d, output logic st, output logic vo, output logic ae,
                          output logic [31:0] pc, output logic [31:0] mr, output logic [31:0] wb);
        if (d == 0) begin
            st = bus0.stall; vo = bus0.valid_out; ae = bus0.addr_err;
            pc = bus0.PC_out; mr = bus0.mem_result; wb = bus0.wb_result;
        end else begin
            st = bus2.stall; vo = bus2.valid_out; ae = bus2.addr_err;
            pc = bus2.PC_out; mr = bus2.mem_result; wb = bus2.wb_result;
        end
    endtask

    task automatic check_out(input string tag, input int d, input logic vo_e,
                             input logic [31:0] pc_e, input logic [31:0] mr_e,
                             input logic [31:0] wb_e, input logic ae_e);
        logic st, vo, ae;
        logic [31:0] pc, mr, wb;
        sample(d, st, vo, ae, pc, mr, wb);
        chk({tag, ".valid_out"}, 32'(vo), 32'(vo_e));
        chk({tag, ".PC_out"}, pc, pc_e);
        chk({tag, ".mem_result"}, mr, mr_e);
        chk({tag, ".wb_result"}, wb, wb_e);
        chk({tag, ".addr_err"}, 32'(ae), 32'(ae_e));
    endtask

    // Presents one instruction at a negedge, holds it while stall is high,
    // counts the stalled cycles, and returns #1 after the retiring edge.
    task automatic do_op(input int d, input logic rd, input logic wr, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rm, output int stalls);
        logic st, vo, ae;
        logic [31:0] p, m, w;
        bit ok;
        @(negedge clk);
        drive(d, 1'b1, rd, wr, pc, alu, rm);
        stalls = 0;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            sample(d, st, vo, ae, p, m, w);
            if (k > 0) chk("valid_out_during_stall", 32'(vo), 32'd0);
            if (!st) begin
                ok = 1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        if (!ok) chk("stall_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    logic        st, vo, ae;
    logic [31:0] p, m, w;
    int          s;
    logic [31:0] oor_val;
    logic        oor_err;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
        oor_val = 32'd0;
        oor_err = 1'b1;
`else
        oor_val = 32'hDEADBEEF;
        oor_err = 1'b0;
`endif
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        drive(2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_w2", 2, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        check_out("reset_w0", 0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        sample(2, st, vo, ae, p, m, w);
        chk("reset_stall", 32'(st), 32'd0);
        rst = 1'b0;

        // Non-memory op: no stall, one-cycle latency
        do_op(2, 1'b0, 1'b0, 32'h40, 32'h55, 32'h0, s);
        chk("alu_stalls", 32'(s), 32'd0);
        check_out("alu", 2, 1'b1, 32'h40, 32'd0, 32'h55, 1'b0);

        // Bubble: valid_out drops, other outputs hold
        @(negedge clk);
        @(posedge clk);
        #1;
        check_out("bubble", 2, 1'b0, 32'h40, 32'd0, 32'h55, 1'b0);

        // Store / load with two wait states
        do_op(2, 1'b0, 1'b1, 32'h44, 32'd1024, 32'hDEADBEEF, s);
        chk("st1024_stalls", 32'(s), 32'd2);
        check_out("st1024", 2, 1'b1, 32'h44, 32'd0, 32'd1024, 1'b0);
        do_op(2, 1'b1, 1'b0, 32'h48, 32'd1024, 32'h0, s);
        chk("ld1024_stalls", 32'(s), 32'd2);
        check_out("ld1024", 2, 1'b1, 32'h48, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

        // Reset in the middle of a store aborts it
        do_op(2, 1'b0, 1'b1, 32'h4C, 32'd1032, 32'h77, s);
        @(negedge clk);
        drive(2, 1'b1, 1'b0, 1'b1, 32'h50, 32'd1032, 32'h22);
        #1;
        sample(2, st, vo, ae, p, m, w);
        chk("abort_stall_hi", 32'(st), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        sample(2, st, vo, ae, p, m, w);
        chk("abort_stall_rst", 32'(st), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        check_out("abort_rst", 2, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        do_op(2, 1'b1, 1'b0, 32'h54, 32'd1032, 32'h0, s);
        chk("ld1032_stalls", 32'(s), 32'd2);
        check_out("ld1032", 2, 1'b1, 32'h54, 32'h77, 32'h77, 1'b0);

        // Read and write both high: store only
        do_op(2, 1'b1, 1'b1, 32'h58, 32'd1036, 32'h33, s);
        chk("rw_stalls", 32'(s), 32'd2);
        check_out("rw", 2, 1'b1, 32'h58, 32'h77, 32'd1036, 1'b0);
        do_op(2, 1'b1, 1'b0, 32'h5C, 32'd1036, 32'h0, s);
        check_out("ld1036", 2, 1'b1, 32'h5C, 32'h33, 32'h33, 1'b0);

        // Low address bits ignored
        do_op(2, 1'b1, 1'b0, 32'h60, 32'd1027, 32'h0, s);
        check_out("ld1027", 2, 1'b1, 32'h60, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

        // Last word in range
        do_op(2, 1'b0, 1'b1, 32'h64, 32'd1276, 32'h0000A5A5, s);
        do_op(2, 1'b1, 1'b0, 32'h68, 32'd1276, 32'h0, s);
        check_out("ld1276", 2, 1'b1, 32'h68, 32'h0000A5A5, 32'h0000A5A5, 1'b0);

        // First word past the end
        do_op(2, 1'b1, 1'b0, 32'h6C, 32'd1280, 32'h0, s);
        chk("ld1280_stalls", 32'(s), 32'd2);
        check_out("ld1280", 2, 1'b1, 32'h6C, oor_val, oor_val, oor_err);
        do_op(2, 1'b0, 1'b0, 32'h70, 32'h99, 32'h0, s);
        check_out("alu_after_oor", 2, 1'b1, 32'h70, oor_val, 32'h99, 1'b0);

        // Zero wait states: back-to-back store then load
        do_op(0, 1'b0, 1'b1, 32'h80, 32'd1028, 32'h11, s);
        chk("w0_st_stalls", 32'(s), 32'd0);
        check_out("w0_st", 0, 1'b1, 32'h80, 32'd0, 32'd1028, 1'b0);
        do_op(0, 1'b1, 1'b0, 32'h84, 32'd1028, 32'h0, s);
        chk("w0_ld_stalls", 32'(s), 32'd0);
        check_out("w0_ld", 0, 1'b1, 32'h84, 32'h11, 32'h11, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stage_ws.md
MEM_STAGE_WS -- requirements
Module: mem_stage_ws

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, datapath width; DEPTH, default 64, data-memory words; WAIT_CYCLES, default 2, memory wait states per access (range 0..15); BASE_ADDR, default 1024, byte address of word 0.
REQ-002 Ports SHALL be, clock and reset first:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
valid_in  in  1  instruction present in this stage
PC_in  in  DATA_W  PC of instruction
ALU_result  in  DATA_W  result or byte address
val_Rm  in  DATA_W  store data
mem_read  in  1  load request
mem_write  in  1  store request
stall  out  1  hold upstream; inputs must stay stable while high
valid_out  out  1  registered result valid
PC_out  out  DATA_W  registered PC
mem_result  out  DATA_W  registered load data
wb_result  out  DATA_W  registered writeback value
addr_err  out  1  registered out-of-range flag (macro-dependent)

Function
REQ-003 Word index SHALL be (ALU_result - BASE_ADDR) >> 2, truncated to clog2(DEPTH) bits; ALU_result[1:0] ignored.
REQ-004 FSM SHALL have states IDLE and WAIT, plus a 4-bit wait counter cnt.
REQ-005 IDLE, valid_in=0: no access; stall=0; next edge valid_out<=0, other outputs hold.
REQ-006 IDLE, valid_in=1, no mem op: stall=0; next edge valid_out<=1, PC_out<=PC_in, wb_result<=ALU_result, mem_result holds.
REQ-007 IDLE, valid_in=1, mem op, WAIT_CYCLES=0: access completes same cycle, stall=0, one-cycle latency.
REQ-008 IDLE, valid_in=1, mem op, WAIT_CYCLES>0: stall=1 combinationally; next edge state<=WAIT, cnt<=WAIT_CYCLES-1, valid_out<=0.
REQ-009 WAIT, cnt!=0: stall=1, cnt decrements, valid_out<=0; WAIT, cnt=0: stall=0, access completes, state<=IDLE.
REQ-010 Total stall cycles per memory op SHALL equal WAIT_CYCLES exactly; non-memory ops never stall.
REQ-011 Completion edge: store writes val_Rm to mem[index]; load sets mem_result<=mem[index] and wb_result<=mem[index]; store sets wb_result<=ALU_result; valid_out<=1; PC_out<=PC_in.
REQ-012 mem_read and mem_write both high SHALL be treated as a store only; mem_result holds.
REQ-013 Loads SHALL return pre-write contents; only one access in flight; no new request accepted while stall=1.
REQ-014 Memory array SHALL be DEPTH x DATA_W, no reset, written only on completion edge.

Reset
REQ-015 rst=1 at an edge SHALL force state<=IDLE, cnt<=0, valid_out<=0, PC_out<=0, mem_result<=0, wb_result<=0, addr_err<=0.
REQ-016 rst during WAIT SHALL abort the access with no memory write; stall=0 while rst=1.
REQ-017 Memory contents SHALL be unaffected by rst.

Configuration
REQ-018 Macro MEM_STAGE_BOUNDS_CHECK_EN SHALL select out-of-range handling.
REQ-019 Defined: address outside [BASE_ADDR, BASE_ADDR+4*DEPTH) on a mem op completes with normal timing, store suppressed, load returns 0, addr_err<=1 with valid_out; addr_err<=0 otherwise.
REQ-020 Undefined: index wraps modulo DEPTH per REQ-003; addr_err tied 0.

Verification
REQ-021 WAIT_CYCLES=2: store val_Rm=0xDEADBEEF at 1024 -> stall high 2 cycles, valid_out 1 on 3rd edge; load 1024 -> wb_result=mem_result=0xDEADBEEF.
REQ-022 Non-memory op ALU_result=0x55, PC_in=0x40 -> no stall, next edge valid_out=1, wb_result=0x55, PC_out=0x40.
REQ-023 WAIT_CYCLES=0: back-to-back store 0x11 at 1028 then load 1028 -> stall never high, load wb_result=0x11.
REQ-024 rst asserted during WAIT of store 0x22 to 1032 -> outputs 0, IDLE; subsequent load 1032 returns prior content, not 0x22.
REQ-025 mem_read=mem_write=1, val_Rm=0x33, addr 1036 -> store performed, wb_result=1036, later load returns 0x33.
REQ-026 With MEM_STAGE_BOUNDS_CHECK_EN, DEPTH=64: load 1024+256 -> wb_result=0, addr_err=1; without macro, same address reads word 0.
